// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter: one holding register per functional unit,
// round-robin selection, and a registered single-beat broadcast to the reservation stations.
module cdb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 4,
    parameter int ADD_TAG_BASE = 7,
    parameter int MUL_TAG_BASE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add1_valid,
    input  logic [DATA_W-1:0] add1_result,
    output logic              add1_ready,
    input  logic              add2_valid,
    input  logic [DATA_W-1:0] add2_result,
    output logic              add2_ready,
    input  logic              add3_valid,
    input  logic [DATA_W-1:0] add3_result,
    output logic              add3_ready,
    input  logic              mult1_valid,
    input  logic [DATA_W-1:0] mult1_result,
    output logic              mult1_ready,
    input  logic              mult2_valid,
    input  logic [DATA_W-1:0] mult2_result,
    output logic              mult2_ready,
    input  logic              ls_valid,
    input  logic [DATA_W-1:0] ls_value,
    input  logic [2:0]        ls_idx,
    output logic              ls_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [5:0]        pending,
    output logic              err_bad_idx
);
    localparam int N_SRC  = 6;
    localparam int LS_SRC = 5;

    logic [N_SRC-1:0]  valid_vec;
    logic [N_SRC-1:0]  ready_vec;
    logic [N_SRC-1:0]  xfer_vec;
    logic [N_SRC-1:0]  load_vec;
    logic [N_SRC-1:0]  grant_vec;
    logic [N_SRC-1:0]  held_reg;
    logic [N_SRC-1:0]  held_next;
    logic [DATA_W-1:0] in_data  [N_SRC];
    logic [TAG_W-1:0]  in_tag   [N_SRC];
    logic [DATA_W-1:0] data_reg [N_SRC];
    logic [TAG_W-1:0]  tag_reg  [N_SRC];
    logic [DATA_W-1:0] sel_data [N_SRC];
    logic [TAG_W-1:0]  sel_tag  [N_SRC];
    logic [2:0]        ptr_reg;
    logic [2:0]        ptr_next;
    logic [2:0]        grant_idx;
    logic              grant_any;
    logic [DATA_W-1:0] win_data;
    logic [TAG_W-1:0]  win_tag;
    logic              ls_idx_ok;
    logic              cdb_valid_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic              err_bad_idx_reg;

    assign valid_vec = {ls_valid, mult2_valid, mult1_valid, add3_valid, add2_valid, add1_valid};
    assign in_data[0] = add1_result;
    assign in_data[1] = add2_result;
    assign in_data[2] = add3_result;
    assign in_data[3] = mult1_result;
    assign in_data[4] = mult2_result;
    assign in_data[5] = ls_value;

    // Index 0 and 7 name no load/store buffer: the value is swallowed, never broadcast.
    assign ls_idx_ok = (ls_idx != 3'd0) && (ls_idx != 3'd7);

    assign ready_vec = {N_SRC{~rst}} & (~held_reg | grant_vec);
    assign xfer_vec  = valid_vec & ready_vec;

    // Round-robin: first held source at or after ptr, wrapping 5 -> 0.
    always_comb begin
        logic [3:0] cand;
        grant_any = 1'b0;
        grant_idx = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, ptr_reg} + 4'(k);
            if (cand >= 4'(N_SRC))
                cand = cand - 4'(N_SRC);
            if (!grant_any && held_reg[cand[2:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_any)
            grant_vec[grant_idx] = 1'b1;
        ptr_next = ptr_reg;
        if (grant_any)
            ptr_next = (grant_idx == 3'(N_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            if (gi < 3) begin : g_add
                assign in_tag[gi]   = TAG_W'(ADD_TAG_BASE + gi);
                assign load_vec[gi] = xfer_vec[gi];
            end else if (gi < LS_SRC) begin : g_mul
                assign in_tag[gi]   = TAG_W'(MUL_TAG_BASE + gi - 3);
                assign load_vec[gi] = xfer_vec[gi];
            end else begin : g_ls
                assign in_tag[gi]   = TAG_W'(ls_idx);
                assign load_vec[gi] = xfer_vec[gi] && ls_idx_ok;
            end

            // A same-edge refill wins over the clear from being granted.
            assign held_next[gi] = load_vec[gi] || (held_reg[gi] && !grant_vec[gi]);
            assign sel_data[gi]  = grant_vec[gi] ? data_reg[gi] : '0;
            assign sel_tag[gi]   = grant_vec[gi] ? tag_reg[gi] : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    held_reg[gi] <= 1'b0;
                    data_reg[gi] <= '0;
                    tag_reg[gi]  <= '0;
                end else begin
                    held_reg[gi] <= held_next[gi];
                    if (load_vec[gi]) begin
                        data_reg[gi] <= in_data[gi];
                        tag_reg[gi]  <= in_tag[gi];
                    end
                end
            end
        end
    endgenerate

    // Grant is one-hot, so OR-reducing the masked entries selects the winner.
    always_comb begin
        win_data = '0;
        win_tag  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            win_data = win_data | sel_data[k];
            win_tag  = win_tag | sel_tag[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg         <= 3'd0;
            cdb_valid_reg   <= 1'b0;
            cdb_tag_reg     <= '0;
            cdb_data_reg    <= '0;
            err_bad_idx_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            cdb_valid_reg <= grant_any;
            if (grant_any) begin
                cdb_tag_reg  <= win_tag;
                cdb_data_reg <= win_data;
            end
            if (xfer_vec[LS_SRC] && !ls_idx_ok)
                err_bad_idx_reg <= 1'b1;
        end
    end

    assign add1_ready  = ready_vec[0];
    assign add2_ready  = ready_vec[1];
    assign add3_ready  = ready_vec[2];
    assign mult1_ready = ready_vec[3];
    assign mult2_ready = ready_vec[4];
    assign ls_ready    = ready_vec[5];
    assign cdb_valid   = cdb_valid_reg;
    assign cdb_tag     = cdb_tag_reg;
    assign cdb_data    = cdb_data_reg;
    assign pending     = held_reg;
    assign err_bad_idx = err_bad_idx_reg;

endmodule
